fetch_ctrl: RTL and testbench

//  Sequences instruction fetch around the PC datapath: issues one request at a time to

---
 rtl/fetch_ctrl.sv | 177 +++++++++++++++++
 tb/tb_fetch_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer between the PC register and decode.
// Latency: request 1 cycle after reset/delivery/redirect; response captured on rvalid,
//   presented to decode the following cycle.
// Backpressure: one outstanding imem request; the word is held in OUT until inst_ready,
//   and pc_en fires only on a real hand-off.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   redirect_valid, redirect_pc     non-sequential next-PC from the select path
//   imem_req/addr/gnt               request channel (addr stable until gnt)
//   imem_rvalid/rdata               response channel (>=1 cycle after gnt)
//   inst_valid/data/pc, inst_ready  valid/ready hand-off to decode
//   pc_en                           PC register advance strobe
//   fault                           sticky misaligned-redirect trap
//
// Optional feature macro MISALIGN_CHECK_EN: when defined, a redirect whose target has
// nonzero low bits parks the block in a FAULT state until reset. When undefined the
// low two target bits are cleared and fault is tied low.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        pc_en,
    output logic        fault
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_OUT   = 3'd3;
`ifdef MISALIGN_CHECK_EN
    localparam logic [2:0] ST_FAULT = 3'd4;
`endif

    logic [2:0]  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] inst_data_q, inst_data_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        squash_q, squash_d;

    logic        redir_act;
    logic [31:0] redir_tgt;
    logic        redir_fault;

`ifdef MISALIGN_CHECK_EN
    logic        fault_q, fault_d;

    // Redirects are ignored while parked in FAULT; only reset leaves it.
    assign redir_act   = redirect_valid && (state_q != ST_IDLE) && (state_q != ST_FAULT);
    assign redir_tgt   = redirect_pc;
    assign redir_fault = redir_act && (redirect_pc[1:0] != 2'b00);
    assign fault       = fault_q;
`else
    logic        unused_redir_lsb;

    assign redir_act        = redirect_valid && (state_q != ST_IDLE);
    assign redir_tgt        = {redirect_pc[31:2], 2'b00};
    assign redir_fault      = 1'b0;
    assign unused_redir_lsb = ^{redirect_pc[1:0], redir_fault};
    assign fault            = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_addr_d  = req_addr_q;
        inst_data_d = inst_data_q;
        inst_pc_d   = inst_pc_q;
        squash_d    = squash_q;
`ifdef MISALIGN_CHECK_EN
        fault_d     = fault_q;
`endif

        if (redir_act) begin
            fetch_pc_d = redir_tgt;
        end

        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                // The request in flight keeps its address; its response is discarded later.
                if (redir_act) squash_d = 1'b1;
                if (imem_gnt)  state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (squash_q || redir_act) begin
                        squash_d = 1'b0;
                        state_d  = ST_REQ;
                    end else begin
                        inst_data_d = imem_rdata;
                        inst_pc_d   = req_addr_q;
                        state_d     = ST_OUT;
                    end
                end else if (redir_act) begin
                    squash_d = 1'b1;
                end
            end
            ST_OUT: begin
                // A redirect beats a same-cycle inst_ready: the held word is abandoned.
                if (redir_act) begin
                    state_d = ST_REQ;
                end else if (inst_ready) begin
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                    state_d    = ST_REQ;
                end
            end
`ifdef MISALIGN_CHECK_EN
            ST_FAULT: state_d = ST_FAULT;
`endif
            default: state_d = ST_IDLE;
        endcase

`ifdef MISALIGN_CHECK_EN
        if (redir_fault) begin
            state_d  = ST_FAULT;
            fault_d  = 1'b1;
            squash_d = 1'b0;
        end
`endif

        // The request address is latched only on entry to REQ so it stays put until gnt.
        if ((state_d == ST_REQ) && (state_q != ST_REQ)) begin
            req_addr_d = fetch_pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_PC;
            req_addr_q  <= 32'h0;
            inst_data_q <= 32'h0;
            inst_pc_q   <= 32'h0;
            squash_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_addr_q  <= req_addr_d;
            inst_data_q <= inst_data_d;
            inst_pc_q   <= inst_pc_d;
            squash_q    <= squash_d;
        end
    end

`ifdef MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`endif

    assign imem_req   = (state_q == ST_REQ);
    assign imem_addr  = req_addr_q;
    assign inst_valid = (state_q == ST_OUT);
    assign inst_data  = inst_data_q;
    assign inst_pc    = inst_pc_q;
    assign pc_en      = inst_valid && inst_ready && !redir_act;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios plus randomized traffic against a
// transaction-level model of the fetch stream.
// Drives inputs at the falling edge, samples outputs 1 time unit later.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        pc_en;
    logic        fault;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .pc_en          (pc_en),
        .fault          (fault)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // stimulus knobs
    bit          want_ready, want_redir, gnt_allow;
    logic [31:0] want_target;
    int          mem_lat;

    // memory responder
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    // fetch-stream model
    logic [31:0] exp_pc;
    bit          have_word, req_open, txn_stale, idle_cycle, in_fault;
    logic [31:0] open_addr;
    logic [31:0] req_log[$];
    int          since_pe;
    int          dut_pe_cnt;

    // last sampled outputs
    logic        s_req, s_valid, s_pc_en, s_fault;
    logic [31:0] s_addr, s_pc, s_data;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_cycle();
        bit          redir, fresh, keep, exp_pe, misal;
        logic [31:0] tgt;
        redir = redirect_valid && !idle_cycle && !in_fault;
        tgt   = redirect_pc & 32'hFFFF_FFFC;
        misal = 1'b0;
`ifdef MISALIGN_CHECK_EN
        misal = redir && (redirect_pc[1:0] != 2'b00);
`endif
        exp_pe = have_word && inst_ready && !redir;

        check("imem_req", {31'b0, imem_req}, {31'b0, !have_word && !mem_busy && !idle_cycle && !in_fault});
        check("inst_valid", {31'b0, inst_valid}, {31'b0, have_word});
        check("pc_en", {31'b0, pc_en}, {31'b0, exp_pe});
        check("fault", {31'b0, fault}, {31'b0, in_fault});
        if (have_word) begin
            check("inst_pc", inst_pc, exp_pc);
            check("inst_data", inst_data, word_of(exp_pc));
        end

        fresh = imem_req && !req_open;
        if (imem_req) begin
            if (fresh) begin
                check("req_addr", imem_addr, exp_pc);
                req_log.push_back(imem_addr);
                open_addr = imem_addr;
                txn_stale = 1'b0;
            end else begin
                check("req_hold", imem_addr, open_addr);
            end
        end
        req_open = imem_req && !imem_gnt;

        keep = imem_rvalid && !txn_stale && !redir && !in_fault;
        if (redir && (imem_req || mem_busy)) txn_stale = 1'b1;

        if (misal) begin
            in_fault  = 1'b1;
            have_word = 1'b0;
        end else if (redir) begin
            exp_pc    = tgt;
            have_word = 1'b0;
        end else if (exp_pe) begin
            exp_pc    = exp_pc + 32'd4;
            have_word = 1'b0;
        end
        if (keep && !misal) have_word = 1'b1;

        since_pe   = exp_pe ? 0 : since_pe + 1;
        idle_cycle = 1'b0;
    endtask

    task automatic cycle();
        @(negedge clk);
        imem_rvalid    = mem_busy && (mem_cnt == 0);
        imem_rdata     = imem_rvalid ? word_of(mem_addr) : 32'h0BAD_0BAD;
        imem_gnt       = imem_req && gnt_allow;
        inst_ready     = want_ready;
        redirect_valid = want_redir;
        redirect_pc    = want_target;
        #1;
        s_req   = imem_req;   s_addr = imem_addr; s_valid = inst_valid;
        s_pc    = inst_pc;    s_data = inst_data; s_pc_en = pc_en; s_fault = fault;
        if (pc_en) dut_pe_cnt++;
        model_cycle();
        if (imem_rvalid) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (imem_gnt) begin
            check("one_outstanding", {31'b0, mem_busy}, 32'h0);
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = mem_lat - 1;
        end
        want_redir = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        want_ready = 1'b0; want_redir = 1'b0; want_target = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        mem_busy = 1'b0; mem_cnt = 0;
        exp_pc = 32'h0; have_word = 1'b0; req_open = 1'b0; txn_stale = 1'b0;
        in_fault = 1'b0; idle_cycle = 1'b1; since_pe = 0; dut_pe_cnt = 0;
        req_log.delete();
        #3;
        check("rst_imem_req", {31'b0, imem_req}, 32'h0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        check("rst_pc_en", {31'b0, pc_en}, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_until_valid(input int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!s_valid && n < budget);
        check("wait_valid", {31'b0, s_valid}, 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        gnt_allow = 1'b1;
        mem_lat = 1;
        do_reset();

        // 1: IDLE cycle, then three back-to-back fetches at 0,4,8
        check("idle_req", {31'b0, imem_req}, 32'h0);
        want_ready = 1'b1;
        repeat (10) cycle();
        check("t1_nreq", req_log.size(), 32'd3);
        if (req_log.size() >= 3) begin
            check("t1_addr0", req_log[0], 32'h0);
            check("t1_addr1", req_log[1], 32'h4);
            check("t1_addr2", req_log[2], 32'h8);
        end
        check("t1_pc_en_cnt", dut_pe_cnt, 32'd3);

        // 2: decode stalls five cycles in OUT
        want_ready = 1'b0;
        repeat (7) cycle();
        check("t2_valid", {31'b0, s_valid}, 32'h1);
        check("t2_pc", s_pc, 32'hC);
        check("t2_data", s_data, word_of(32'hC));
        check("t2_req", {31'b0, s_req}, 32'h0);
        check("t2_pc_en_cnt", dut_pe_cnt, 32'd3);

        // 5: redirect 0x80 together with inst_ready in OUT
        want_ready = 1'b1; want_redir = 1'b1; want_target = 32'h80;
        cycle();
        check("t5_valid", {31'b0, s_valid}, 32'h1);
        check("t5_pc_en", {31'b0, s_pc_en}, 32'h0);
        cycle();
        check("t5_req", {31'b0, s_req}, 32'h1);
        check("t5_addr", s_addr, 32'h80);

        // 3: redirect 0x100 in WAIT on the rvalid cycle
        want_redir = 1'b1; want_target = 32'h100;
        cycle();
        // 4: redirect 0x40 on the first REQ cycle, gnt held off three cycles
        gnt_allow = 1'b0; want_redir = 1'b1; want_target = 32'h40;
        cycle();
        check("t3_req", {31'b0, s_req}, 32'h1);
        check("t3_addr", s_addr, 32'h100);
        check("t3_valid", {31'b0, s_valid}, 32'h0);
        repeat (2) begin
            cycle();
            check("t4_hold", s_addr, 32'h100);
        end
        gnt_allow = 1'b1;
        cycle();
        check("t4_gnt_addr", s_addr, 32'h100);
        cycle();
        cycle();
        check("t4_req", {31'b0, s_req}, 32'h1);
        check("t4_addr", s_addr, 32'h40);
        check("t4_pc_en_cnt", dut_pe_cnt, 32'd3);

        // 6: misaligned redirect 0x102 while holding a word
        want_ready = 1'b0;
        run_until_valid(20);
        want_redir = 1'b1; want_target = 32'h102;
        cycle();
`ifdef MISALIGN_CHECK_EN
        repeat (5) begin
            cycle();
            check("t6_fault", {31'b0, s_fault}, 32'h1);
            check("t6_req", {31'b0, s_req}, 32'h0);
            check("t6_valid", {31'b0, s_valid}, 32'h0);
        end
        do_reset();
`else
        cycle();
        check("t6_req", {31'b0, s_req}, 32'h1);
        check("t6_addr", s_addr, 32'h100);
        check("t6_fault", {31'b0, s_fault}, 32'h0);
`endif

        // 7: address wrap from 0xFFFF_FFFC to 0
        want_ready = 1'b0;
        run_until_valid(20);
        want_redir = 1'b1; want_target = 32'hFFFF_FFFC;
        cycle();
        run_until_valid(20);
        check("t7_pc", s_pc, 32'hFFFF_FFFC);
        want_ready = 1'b1;
        cycle();
        cycle();
        check("t7_req", {31'b0, s_req}, 32'h1);
        check("t7_addr", s_addr, 32'h0);

        // randomized traffic, with one reset in the middle
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            want_ready = ($urandom_range(0, 3) != 0);
            gnt_allow  = ($urandom_range(0, 2) != 0);
            mem_lat    = $urandom_range(1, 3);
            want_redir = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 2))
                0:       want_target = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
                1:       want_target = $urandom_range(0, 255) << 2;
                default: want_target = $urandom;
            endcase
`ifdef MISALIGN_CHECK_EN
            want_target[1:0] = 2'b00;
`endif
            cycle();
            check("progress", {31'b0, since_pe <= 100}, 32'h1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
